// File: rtl/fp_mult_arbiter.sv
// rtl/fp_mult_arbiter.sv - round-robin front end for one shared DLFloat16 multiplier
// Two-stage pipeline: S1 registers the winner's operands, S2 captures the product.
module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [19:0]          mul_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [19:0]          rsp_data,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [1:0]           rsp_exc
);

  localparam logic [19:0] RES_ONES = 20'hFFFFF;

  logic            v1;
  logic            v2;
  logic [TAGW-1:0] tag1;
  logic [TAGW-1:0] rr;

  logic            s2_take;
  logic            s1_free;
  logic            grant_any;
  logic            grant;
  logic [TAGW-1:0] grant_idx;

  logic [15:0]     a_lane [NREQ];
  logic [15:0]     b_lane [NREQ];

  // Modular increment that also works for non-power-of-two NREQ.
  function automatic logic [TAGW-1:0] wrap_add(input logic [TAGW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return TAGW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_lane[i] = req_a[16*i +: 16];
      b_lane[i] = req_b[16*i +: 16];
    end
  end

  assign s2_take = v1 & (~v2 | rsp_ready);
  assign s1_free = ~v1 | s2_take;

  // Search starts at rr and wraps; the first valid requester wins.
  always_comb begin
    logic [TAGW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_add(rr, k);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant = grant_any & s1_free;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  // Stage 1: operands feed the combinational multiplier directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      mul_a <= 16'h0000;
      mul_b <= 16'h0000;
      tag1  <= '0;
      rr    <= '0;
    end else if (grant) begin
      v1    <= 1'b1;
      mul_a <= a_lane[grant_idx];
      mul_b <= b_lane[grant_idx];
      tag1  <= grant_idx;
      rr    <= wrap_add(grant_idx, 1);
    end else if (s2_take) begin
      v1    <= 1'b0;
    end
  end

  // Stage 2: holds the product until the consumer accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      rsp_data <= 20'h00000;
      rsp_tag  <= '0;
      rsp_exc  <= 2'b00;
    end else if (s2_take) begin
      v2       <= 1'b1;
      rsp_data <= mul_c;
      rsp_tag  <= tag1;
      rsp_exc  <= {mul_c == RES_ONES, mul_c == 20'h00000};
    end else if (rsp_ready) begin
      v2       <= 1'b0;
    end
  end

  assign rsp_valid = v2;

endmodule
